// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key-code and 7-segment lookup tables for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  // index {row, col}; row 3 holds *, 0, #, D
  localparam logic [15:0][3:0] KEY_LUT = 64'hDF0E_C987_B654_A321;
  localparam logic [15:0][6:0] SEG_LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                          7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    return r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_debounce_sync.sv
// keypad_debounce_sync: two-flop row synchronizer plus the shared scan/debounce counter
module keypad_debounce_sync #(
  parameter int CW = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    filas_raw,
  input  logic          clr,
  input  logic          inc,
  output logic [3:0]    rows_s,
  output logic [CW-1:0] cnt,
  output logic          stable
);
  logic [3:0] meta;
  assign stable = cnt == CW'(STABLE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      rows_s <= '0;
      cnt    <= '0;
    end else begin
      meta   <= filas_raw;
      rows_s <= meta;
      cnt    <= clr ? '0 : cnt + CW'(inc);
    end
  end
endmodule

// File: rtl/keypad_lecture.sv
// keypad_lecture: 4x4 keypad scanner with debounce and hex decode; KEYPAD_SEVENSEG_EN adds 7-segment output d
module keypad_lecture
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas_raw,
  output logic [3:0] columnas,
  output logic [3:0] sample,
  output logic       key_valid
`ifdef KEYPAD_SEVENSEG_EN
  ,
  output logic [6:0] d
`endif
);
  localparam int CW = $clog2(SCAN_DIV > DEBOUNCE_CYCLES ? SCAN_DIV : DEBOUNCE_CYCLES);
  state_t state;
  logic [1:0] col;
  logic [3:0] rows_s, rows_l;
  logic [CW-1:0] cnt;
  logic stable, clr, inc, rows_nz, scan_done;
  keypad_debounce_sync #(.CW(CW), .STABLE_CYCLES(DEBOUNCE_CYCLES)) u_sync (
    .clk(clk), .rst(rst), .filas_raw(filas_raw), .clr(clr), .inc(inc),
    .rows_s(rows_s), .cnt(cnt), .stable(stable)
  );
  assign rows_nz   = |rows_s;
  assign scan_done = cnt == CW'(SCAN_DIV - 1);
  // HELD always clears so the release window starts from zero
  assign clr = (state == SCAN)      ? (rows_nz || scan_done) :
               (state == DEB_PRESS) ? (rows_s != rows_l || stable) :
               (state == HELD)      ? 1'b1 : (rows_nz || stable);
  assign inc = state != HELD;
  assign columnas = 4'b0001 << col;
`ifdef KEYPAD_SEVENSEG_EN
  assign d = SEG_LUT[sample];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= '0;
      rows_l    <= '0;
      sample    <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (rows_nz) begin
            rows_l <= rows_s;
            state  <= DEB_PRESS;
          end else if (scan_done) col <= col + 2'd1;
        end
        DEB_PRESS: begin
          if (rows_s != rows_l) state <= SCAN;
          else if (stable) begin
            state     <= HELD;
            sample    <= KEY_LUT[{lowest_row(rows_l), col}];
            key_valid <= 1'b1;
          end
        end
        HELD: if (!rows_nz) state <= DEB_RELEASE;
        default: begin
          if (rows_nz) state <= HELD;
          else if (stable) begin
            state <= SCAN;
            col   <= col + 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_lecture.sv
// tb_keypad_lecture: directed checks of scanning, debounce, decode and reset with a small keypad model
module tb_keypad_lecture;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] filas_raw, columnas, sample, force_rows = '0;
  logic key_valid;
  logic [15:0] keys = '0;
  int errors = 0, checks = 0, pulses = 0;
`ifdef KEYPAD_SEVENSEG_EN
  logic [6:0] d;
`endif
  keypad_lecture #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .filas_raw(filas_raw), .columnas(columnas),
    .sample(sample), .key_valid(key_valid)
`ifdef KEYPAD_SEVENSEG_EN
    , .d(d)
`endif
  );
  always #5 clk = ~clk;
  // pressed key (r,c) closes row r onto column c
  always_comb begin
    filas_raw = force_rows;
    for (int r = 0; r < 4; r++) filas_raw[r] = filas_raw[r] | (|(keys[r*4 +: 4] & columnas));
  end
  always @(negedge clk) if (key_valid) pulses++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press_release(input int r, input int c, input logic [3:0] code);
    int t, n, p0;
    keys[r*4+c] = 1'b1;
    t = 0;
    while (filas_raw == 4'h0 && t < 40) begin tick(); t++; end
    n = 0;
    do begin tick(); n++; end while (!key_valid && n < 40);
    check("latency", n, 11);
    check("sample", {28'h0, sample}, {28'h0, code});
    check("col_frozen", {28'h0, columnas}, 32'h1 << c);
    tick();
    check("one_cycle", {31'h0, key_valid}, 32'h0);
    p0 = pulses;
    repeat (8) tick();
    check("held_col", {28'h0, columnas}, 32'h1 << c);
    check("single_pulse", pulses, p0);
    keys[r*4+c] = 1'b0;
    repeat (10) tick();
    check("rel_hold", {28'h0, columnas}, 32'h1 << c);
    tick();
    check("rel_next", {28'h0, columnas}, 32'h1 << ((c + 1) % 4));
  endtask
  initial begin
    int t, p0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_col", {28'h0, columnas}, 32'h1);
    check("rst_sample", {28'h0, sample}, 32'h0);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("scan_col", {28'h0, columnas}, 32'h1 << ((k / 4) % 4));
    end
    check("scan_no_pulse", pulses, 0);
    press_release(1, 2, 4'h6);
`ifdef KEYPAD_SEVENSEG_EN
    check("seg6", {25'h0, d}, 32'h7D);
`endif
    repeat (4) tick();
    check("bounce_start_col", {28'h0, columnas}, 32'h1);
    p0 = pulses;
    force_rows = 4'b1000;
    repeat (4) tick();
    force_rows = 4'b0000;
    repeat (6) tick();
    check("bounce_resume", {28'h0, columnas}, 32'h1);
    tick();
    check("bounce_rotate", {28'h0, columnas}, 32'h2);
    check("bounce_no_pulse", pulses, p0);
    check("bounce_sample", {28'h0, sample}, 32'h6);
    press_release(3, 0, 4'hE);
    press_release(3, 2, 4'hF);
`ifdef KEYPAD_SEVENSEG_EN
    check("segF", {25'h0, d}, 32'h71);
`endif
    t = 0;
    while (columnas != 4'b0010 && t < 20) begin tick(); t++; end
    check("multi_col", {28'h0, columnas}, 32'h2);
    force_rows = 4'b0101;
    t = 0;
    do begin tick(); t++; end while (!key_valid && t < 40);
    check("multi_sample", {28'h0, sample}, 32'h2);
    check("multi_frozen", {28'h0, columnas}, 32'h2);
`ifdef KEYPAD_SEVENSEG_EN
    check("seg2", {25'h0, d}, 32'h5B);
`endif
    force_rows = 4'b0000;
    repeat (14) tick();
    keys[9] = 1'b1;
    t = 0;
    while (filas_raw == 4'h0 && t < 40) begin tick(); t++; end
    repeat (5) tick();
    p0 = pulses;
    rst = 1'b1;
    keys = '0;
    tick();
    check("mid_rst_col", {28'h0, columnas}, 32'h1);
    check("mid_rst_sample", {28'h0, sample}, 32'h0);
    check("mid_rst_valid", {31'h0, key_valid}, 32'h0);
    rst = 1'b0;
    repeat (12) tick();
    check("mid_rst_no_pulse", pulses, p0);
    press_release(2, 1, 4'h8);
`ifdef KEYPAD_SEVENSEG_EN
    check("seg8", {25'h0, d}, 32'h7F);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_lecture.md
Name: keypad_lecture

Overview:
- Scans a 4x4 matrix keypad by driving one column at a time and reading the four row lines.
- Synchronizes and debounces the rows, then decodes the pressed key into a 4-bit hex code (`sample`) with a one-cycle `key_valid` strobe.
- Sits between the keypad pins and the display path; `sample` feeds the 7-segment decoder and multiplexer.

Parameters:
- SCAN_DIV, 50000: clock cycles each column stays driven while scanning (min 2).
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles required to accept a press or a release (min 2).

Ports:
- clk, input, 1: single system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- filas_raw, input, 4: raw asynchronous row inputs, active-high (external pull-downs); bit i = row i.
- columnas, output, 4: one-hot active-high column drive; bit j = column j.
- sample, output, 4: code of the last accepted key; holds until the next accepted press.
- key_valid, output, 1: one-cycle pulse, in the same cycle `sample` takes its new value.

Behaviour:
- Reset values: columnas=4'b0001, sample=4'h0, key_valid=0, state=SCAN, all counters 0, synchronizer flops 0.
- Row synchronizer: 2-flop synchronizer per bit. rows_s = filas_raw delayed by 2 cycles. All decisions use rows_s only.
- States: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
- SCAN
  - Counter increments each cycle.
  - At SCAN_DIV-1 the counter clears and columnas rotates left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - If rows_s != 0: latch rows_s and the current column index, clear the counter, go to DEB_PRESS.
  - The column does not rotate in that cycle.
- DEB_PRESS
  - Columns are frozen.
  - If rows_s != latched rows: clear the counter and return to SCAN, resuming the rotation from the same column.
  - Otherwise the counter increments. On the cycle the count reaches DEBOUNCE_CYCLES-1 with rows still matching: go to HELD and register sample = decode(row, col) and key_valid=1.
- Latency: if rows_s first becomes nonzero in cycle n, key_valid is high in cycle n+DEBOUNCE_CYCLES+1.
- HELD
  - Columns are frozen and no further key_valid is produced.
  - When rows_s==0: clear the counter and go to DEB_RELEASE.
- DEB_RELEASE
  - If rows_s != 0: return to HELD (no new key_valid).
  - After DEBOUNCE_CYCLES consecutive zero cycles: go to SCAN, rotate to the next column, clear the counter.
- Decode (row r, column c), in column order c=0..3:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
  - Digits encode their own value; A–D encode 0xA–0xD.
- Multiple rows asserted: the lowest-index set bit of the latched row vector wins. Multiple keys in other columns are ignored until release.
- rst asserted in any state: all registers return to their reset values on the next edge. An in-progress press produces no key_valid.
- Counters are sized by $clog2 of the larger parameter and never wrap inside a state.

Optional Feature:
- KEYPAD_SEVENSEG_EN: when defined, adds output d[6:0], a combinational hex-to-7-segment decode of `sample`.
  - Segments are active-high; d[0]=a … d[6]=g.
  - All 16 codes are shown as 0–9, A, b, C, d, E, F.
  - Examples: 0 -> 7'h3F, 1 -> 7'h06, 8 -> 7'h7F, F -> 7'h71.
- When not defined: port d and its logic are absent. All other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - state enum (SCAN, DEB_PRESS, HELD, DEB_RELEASE);
  - the 4x4 key-code lookup constant;
  - the 16-entry 7-segment constant.
- One natural sub-module: keypad_debounce_sync (2-flop synchronizer plus stable-count compare). The FSM and decode stay in keypad_lecture.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, no rows for 20 cycles -> columnas cycles 0001, 0010, 0100, 1000, each for 4 cycles; sample=0; key_valid never high.
- Hold filas_raw=4'b0010 only while columnas=0100 (key 6) for 20 cycles -> exactly one key_valid pulse, 11 cycles after the row goes high; sample=4'h6; columnas frozen at 0100.
- Row 3 held while columnas=0001 for 4 cycles, then dropped -> bounce rejected: no key_valid, scanning resumes from 0001.
- Key * (r3, c0) pressed, released, then key # (r3, c2) pressed -> sample E then F; two pulses; columnas advances to 0010 after release debounce.
- Rows 4'b0101 held at column 1 -> sample=4'h2 (row 0 wins).
- Assert rst during DEB_PRESS -> next cycle columnas=0001, sample=0, no key_valid. With KEYPAD_SEVENSEG_EN defined, sample=8 gives d=7'h7F.
